// File: rtl/rle_unpack_writer.sv
// Expands (symbol, repeat-count) pairs into a memory frame: addr 0 holds the
// payload length, addr 1..len the expanded bytes. Optional macro: RLE_UNPACK_OVF_EN.
module rle_unpack_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_repeats,
  input  logic              i_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_len
`ifdef RLE_UNPACK_OVF_EN
  ,
  output logic              o_overflow
`endif
);

  localparam logic [ADDR_W-1:0] CAP = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_EXPAND,
    S_HEADER,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] olen_q, olen_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              full;
`ifdef RLE_UNPACK_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  // The payload pointer is always len+1, so only the length is stored.
  assign full = (len_q == CAP);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    olen_d      = olen_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    done_d      = done_q;
`ifdef RLE_UNPACK_OVF_EN
    ovf_d       = ovf_q;
`endif
    o_ready     = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_ACCEPT;
          len_d   = '0;
          done_d  = 1'b0;
`ifdef RLE_UNPACK_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_ACCEPT: begin
        o_ready = 1'b1;
        if (i_valid) begin
          if (i_repeats != '0) begin
            data_d  = i_data;
            cnt_d   = i_repeats;
            last_d  = i_last;
            state_d = S_EXPAND;
          end else if (i_last) begin
            state_d = S_HEADER;
          end
        end
      end
      S_EXPAND: begin
        if (!full) begin
          o_mem_we    = 1'b1;
          o_mem_addr  = len_q + ADDR_W'(1);
          o_mem_wdata = data_q;
          len_d       = len_q + ADDR_W'(1);
        end else begin
`ifdef RLE_UNPACK_OVF_EN
          ovf_d = 1'b1;
`endif
        end
        cnt_d = cnt_q - DATA_W'(1);
        if (cnt_q == DATA_W'(1)) begin
          state_d = last_q ? S_HEADER : S_ACCEPT;
        end
      end
      S_HEADER: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = '0;
        o_mem_wdata = DATA_W'(len_q);
        olen_d      = len_q;
        done_d      = 1'b1;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from state, so the reset cycle itself must be masked.
    if (i_reset) begin
      o_ready     = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      olen_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RLE_UNPACK_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      olen_q  <= olen_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef RLE_UNPACK_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign o_done = done_q;
  assign o_len  = olen_q;
`ifdef RLE_UNPACK_OVF_EN
  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_rle_unpack_writer.sv
// Scoreboard bench for rle_unpack_writer: stimulus queues expected writes,
// a negedge monitor pops and compares every memory write.
module tb_rle_unpack_writer;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_data = '0;
  logic [7:0] i_repeats = '0;
  logic       i_last = 1'b0;
  logic       o_mem_we;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_wdata;
  logic       o_done;
  logic [7:0] o_len;
`ifdef RLE_UNPACK_OVF_EN
  logic       o_overflow;
`endif

  rle_unpack_writer #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_repeats   (i_repeats),
    .i_last      (i_last),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_done      (o_done),
    .o_len       (o_len)
`ifdef RLE_UNPACK_OVF_EN
    ,
    .o_overflow  (o_overflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int mlen = 0;
  int rises = 0;
  logic done_prev = 1'b0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (o_done && !done_prev) rises++;
    done_prev = o_done;
    if (o_mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(o_mem_addr), -1);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("write_addr", int'(o_mem_addr), int'(e[15:8]));
        chk("write_data", int'(o_mem_wdata), int'(e[7:0]));
      end
    end
  end

  task automatic push_bytes(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      if (mlen < 255) begin
        exp_q.push_back({8'(mlen + 1), 8'(d)});
        mlen++;
      end
    end
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    mlen = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the transfer edge.
  task automatic send_pair(input int d, input int n, input bit last, input bit model);
    bit ok;
    if (model) begin
      push_bytes(d, n);
      if (last) exp_q.push_back({8'h00, 8'(mlen)});
    end
    i_valid = 1'b1;
    i_data = 8'(d);
    i_repeats = 8'(n);
    i_last = last;
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge i_clk);
      if (o_ready) ok = 1'b1;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_data = '0;
    i_repeats = '0;
    i_last = 1'b0;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input string name, input int exp_len);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge i_clk);
      if (o_done) ok = 1'b1;
    end
    chk({name, "_done"}, int'(ok), 1);
    chk({name, "_len"}, int'(o_len), exp_len);
    chk({name, "_pending"}, exp_q.size(), 0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int r0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_we", int'(o_mem_we), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_wdata", int'(o_mem_wdata), 0);
    chk("rst_len", int'(o_len), 0);
    @(posedge i_clk); #1;

    // (5,3),(9,1 last): 5,5,5,9 then header 4
    start_frame();
    send_pair(5, 3, 0, 1);
    send_pair(9, 1, 1, 1);
    wait_done("basic", 4);
`ifdef RLE_UNPACK_OVF_EN
    chk("basic_ovf", int'(o_overflow), 0);
`endif

    // 120 single-byte pairs with i_valid toggled
    start_frame();
    for (int k = 1; k <= 120; k++) begin
      send_pair(k, 1, k == 120, 1);
      @(posedge i_clk); #1;
    end
    wait_done("stream120", 120);

    // zero-count pair consumed in one cycle
    start_frame();
    send_pair(7, 0, 0, 1);
    @(negedge i_clk);
    chk("zero_pair_ready", int'(o_ready), 1);
    @(posedge i_clk); #1;
    send_pair(8, 2, 1, 1);
    wait_done("zero_pair", 2);

    // capacity: 300 bytes offered, 255 kept
    start_frame();
    send_pair(1, 200, 0, 1);
    send_pair(2, 100, 1, 1);
    wait_done("cap", 255);
`ifdef RLE_UNPACK_OVF_EN
    chk("cap_ovf", int'(o_overflow), 1);
`endif

    // reset during EXPAND of (3,10): only addr1 written before reset
    start_frame();
    exp_q.push_back({8'd1, 8'd3});
    send_pair(3, 10, 0, 0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rstmid_we", int'(o_mem_we), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rstmid_ready", int'(o_ready), 0);
    chk("rstmid_done", int'(o_done), 0);
    repeat (5) @(posedge i_clk);
    #1;
    chk("rstmid_pending", exp_q.size(), 0);
    start_frame();
    send_pair(4, 1, 1, 1);
    wait_done("after_rst", 1);

    // i_start during EXPAND is ignored, done rises once
    start_frame();
    send_pair(6, 5, 1, 1);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    r0 = rises;
    wait_done("start_ignored", 5);
    repeat (5) @(posedge i_clk);
    #1;
    chk("start_ignored_rises", rises - r0, 1);
    chk("start_ignored_done_hold", int'(o_done), 1);

    chk("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rle_unpack_writer.md
RLE_UNPACK_WRITER -- requirements
Module: rle_unpack_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width; capacity CAP = 2^ADDR_W - 1 payload bytes.
REQ-002 SHALL have parameter DATA_W, default 8, symbol and count width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  sole clock, all logic on rising edge.
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 i_start  in  1  one-cycle pulse, begins a new frame; ignored unless in IDLE or DONE.
REQ-007 i_valid  in  1  pair offered on i_data/i_repeats.
REQ-008 o_ready  out  1  block accepts a pair this cycle.
REQ-009 i_data  in  DATA_W  symbol value.
REQ-010 i_repeats  in  DATA_W  occurrence count of i_data (0 = no bytes).
REQ-011 i_last  in  1  marks final pair of frame, sampled with the pair.
REQ-012 o_mem_we  out  1  memory write strobe.
REQ-013 o_mem_addr  out  ADDR_W  write address.
REQ-014 o_mem_wdata  out  DATA_W  write data.
REQ-015 o_done  out  1  frame complete, level.
REQ-016 o_len  out  ADDR_W  payload bytes written in last frame.

Function
REQ-017 SHALL write the expanded frame as: address 0 = payload length, addresses 1..len = expanded bytes in arrival order.
REQ-018 States SHALL be IDLE, ACCEPT, EXPAND, HEADER, DONE.
REQ-019 IDLE/DONE + i_start -> ACCEPT; payload pointer := 1, length := 0, o_done := 0.
REQ-020 o_ready SHALL be 1 only in ACCEPT; a pair transfers on the cycle i_valid & o_ready are both 1.
REQ-021 On transfer with i_repeats != 0 -> EXPAND, latching data, count and last; with i_repeats == 0 -> stay in ACCEPT, or go to HEADER if i_last.
REQ-022 EXPAND SHALL assert o_mem_we for exactly one cycle per byte, address incrementing by 1, one byte per cycle, no gaps.
REQ-023 First byte write SHALL occur the cycle after transfer (latency 1); a pair of count N occupies N cycles of EXPAND.
REQ-024 After the last byte of a pair: latched last -> HEADER, else -> ACCEPT.
REQ-025 HEADER SHALL write length to address 0 in one cycle, then -> DONE with o_done = 1 and o_len = length.
REQ-026 o_done SHALL hold until the next accepted i_start or reset.
REQ-027 When length reaches CAP, further bytes SHALL be discarded (no write, pointer frozen); remaining pairs are still accepted and consumed until i_last.
REQ-028 i_start during ACCEPT, EXPAND or HEADER SHALL be ignored.
REQ-029 Inputs other than i_start SHALL be ignored outside ACCEPT.

Reset
REQ-030 Reset SHALL force IDLE; o_ready, o_mem_we, o_done = 0; o_mem_addr, o_mem_wdata, o_len = 0.
REQ-031 Reset mid-frame SHALL abort without any further write in the reset cycle or after it.

Configuration
REQ-032 Macro RLE_UNPACK_OVF_EN defined: SHALL add output o_overflow (1 bit), set when a byte is discarded per REQ-027, cleared on i_start or reset.
REQ-033 Macro undefined: o_overflow SHALL not exist; discarding per REQ-027 is unchanged and silent.

Verification
REQ-034 Pairs (5,3),(9,1 last) -> writes addr1..4 = 5,5,5,9, then addr0 = 4; o_done = 1, o_len = 4.
REQ-035 120 pairs (k,1), k = 1..120, last on 120, i_valid toggled every other cycle -> addr k = k, addr0 = 120, no lost or duplicate writes.
REQ-036 Pairs (7,0),(8,2 last) -> only addr1,2 = 8, addr0 = 2; zero-count pair consumed in one cycle.
REQ-037 Pairs (1,200),(2,100 last), ADDR_W = 8 -> 255 payload writes, addr0 = 255; with RLE_UNPACK_OVF_EN o_overflow = 1.
REQ-038 Reset asserted during EXPAND of (3,10) -> o_mem_we = 0 from reset cycle on, state IDLE; subsequent i_start and pair (4,1 last) -> addr1 = 4, addr0 = 1.
REQ-039 i_start pulsed during EXPAND -> ignored; frame completes normally and o_done rises once.
